// File: rtl/complementary_unit_pkg.sv
// Shared nnARM datapath definitions for the complementary unit: word width,
// incrementer group size, the most-negative word and the mode encoding.
package complementary_unit_pkg;
   localparam int WordWidth  = 32;
   localparam int GroupWidth = 4;
   localparam logic [WordWidth-1:0] MostNegative = 32'h8000_0000;
   localparam logic TwosMode = 1'b0;
   localparam logic OnesMode = 1'b1;
endpackage

// File: rtl/complementary_core.sv
// Combinational negation core: bitwise inversion followed by a 4-bit-group
// carry-lookahead incrementer, plus raw zero and overflow detection.
module complementary_core
   import complementary_unit_pkg::*;
(
   input  logic                 mode,
   input  logic [WordWidth-1:0] operand,
   output logic [WordWidth-1:0] result,
   output logic                 zero,
   output logic                 overflow
);
   localparam int Groups = WordWidth / GroupWidth;

   logic [WordWidth-1:0] inv_s;
   logic [Groups-1:0]    group_carry_s;
   logic [Groups-2:0]    group_prop_s;

   assign inv_s = ~operand;
   assign group_carry_s[0] = (mode == TwosMode);

   // An incrementer carries into a group only when every lower bit is one,
   // so the group carry is the injected +1 ANDed with all lower group propagates.
   for (genvar g = 1; g < Groups; g++) begin : g_lookahead
      assign group_carry_s[g] = group_carry_s[0] & (&group_prop_s[g-1:0]);
   end

   for (genvar g = 0; g < Groups; g++) begin : g_group
      logic [GroupWidth-1:0] bits_s;
      logic [GroupWidth-1:0] carry_s;

      assign bits_s     = inv_s[g*GroupWidth +: GroupWidth];
      assign carry_s[0] = group_carry_s[g];

      for (genvar b = 1; b < GroupWidth; b++) begin : g_bit
         assign carry_s[b] = carry_s[b-1] & bits_s[b-1];
      end

      if (g < Groups - 1) begin : g_prop
         assign group_prop_s[g] = &bits_s;
      end

      assign result[g*GroupWidth +: GroupWidth] = bits_s ^ carry_s;
   end

   assign zero     = (result == {WordWidth{1'b0}});
   assign overflow = (mode == TwosMode) && (operand == MostNegative);
endmodule

// File: rtl/complementary_unit.sv
// Registered two's/ones complement unit with one-cycle latency.
// Optional zero/overflow flag ports are enabled by COMPLEMENTARY_FLAGS_EN.
module complementary_unit
   import complementary_unit_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_Valid,
   input  logic                 in_OnesComplement,
   input  logic [WordWidth-1:0] in_Operand,
   output logic                 out_Valid,
   output logic [WordWidth-1:0] out_Result
`ifdef COMPLEMENTARY_FLAGS_EN
   ,
   output logic                 out_Zero,
   output logic                 out_Overflow
`endif
);
   logic [WordWidth-1:0] core_result_s;
   logic                 core_zero_s;
   logic                 core_overflow_s;
   logic                 valid_r;
   logic [WordWidth-1:0] result_r;

   complementary_core u_core (
      .mode     (in_OnesComplement),
      .operand  (in_Operand),
      .result   (core_result_s),
      .zero     (core_zero_s),
      .overflow (core_overflow_s)
   );

   // Valid pipeline and result register; result holds across idle cycles.
   always_ff @(posedge clock) begin
      if (!reset) begin
         valid_r  <= 1'b0;
         result_r <= {WordWidth{1'b0}};
      end else begin
         valid_r <= in_Valid;
         if (in_Valid) begin
            result_r <= core_result_s;
         end else begin
            result_r <= result_r;
         end
      end
   end

   assign out_Valid  = valid_r;
   assign out_Result = result_r;

`ifdef COMPLEMENTARY_FLAGS_EN
   logic zero_r;
   logic overflow_r;

   // Status flag registers, loaded alongside the result.
   always_ff @(posedge clock) begin
      if (!reset) begin
         zero_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else if (in_Valid) begin
         zero_r     <= core_zero_s;
         overflow_r <= core_overflow_s;
      end else begin
         zero_r     <= zero_r;
         overflow_r <= overflow_r;
      end
   end

   assign out_Zero     = zero_r;
   assign out_Overflow = overflow_r;
`else
   logic unused_flags_s;
   assign unused_flags_s = core_zero_s ^ core_overflow_s;
`endif
endmodule

// File: tb/tb_complementary_unit.sv
// Scoreboard bench for complementary_unit: directed vectors push expected
// results into a queue that a negedge monitor pops whenever out_Valid is high.
module tb_complementary_unit;
   import complementary_unit_pkg::*;

   typedef struct packed {
      logic [WordWidth-1:0] result;
      logic                 zero;
      logic                 ovf;
   } exp_t;

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 in_Valid;
   logic                 in_OnesComplement;
   logic [WordWidth-1:0] in_Operand;
   logic                 out_Valid;
   logic [WordWidth-1:0] out_Result;
`ifdef COMPLEMENTARY_FLAGS_EN
   logic                 out_Zero;
   logic                 out_Overflow;
`endif

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   complementary_unit dut (
      .clock             (clock),
      .reset             (reset),
      .in_Valid          (in_Valid),
      .in_OnesComplement (in_OnesComplement),
      .in_Operand        (in_Operand),
      .out_Valid         (out_Valid),
      .out_Result        (out_Result)
`ifdef COMPLEMENTARY_FLAGS_EN
      ,
      .out_Zero          (out_Zero),
      .out_Overflow      (out_Overflow)
`endif
   );

   task automatic check(input string name, input logic [WordWidth-1:0] act,
                        input logic [WordWidth-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      check(name, {{(WordWidth-1){1'b0}}, act}, {{(WordWidth-1){1'b0}}, req});
   endtask

   // Drive one cycle; expected result queued only when the operand is accepted.
   task automatic drive(input logic v, input logic m, input logic [WordWidth-1:0] op,
                        input logic [WordWidth-1:0] res, input logic z, input logic o);
      exp_t e;
      in_Valid          = v;
      in_OnesComplement = m;
      in_Operand        = op;
      e.result = res;
      e.zero   = z;
      e.ovf    = o;
      if (v && reset) exp_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle(input string name, input logic [WordWidth-1:0] res,
                             input logic z, input logic o);
      check_bit({name, "_valid"}, out_Valid, 1'b0);
      check({name, "_result"}, out_Result, res);
`ifdef COMPLEMENTARY_FLAGS_EN
      check_bit({name, "_zero"}, out_Zero, z);
      check_bit({name, "_ovf"}, out_Overflow, o);
`else
      if (z === 1'b1 && o === 1'b1) $display("note: flags not built");
`endif
   endtask

   // Monitor: compare every presented result against the scoreboard head.
   always @(negedge clock) begin
      exp_t e;
      if (out_Valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual=%h required=no_output", out_Result);
         end else begin
            e = exp_q.pop_front();
            check("result", out_Result, e.result);
`ifdef COMPLEMENTARY_FLAGS_EN
            check_bit("zero", out_Zero, e.zero);
            check_bit("overflow", out_Overflow, e.ovf);
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset             = 1'b0;
      in_Valid          = 1'b0;
      in_OnesComplement = TwosMode;
      in_Operand        = 32'h0000_0000;
      repeat (2) @(posedge clock);
      #1;
      check_idle("reset_state", 32'h0000_0000, 1'b0, 1'b0);
      reset = 1'b1;

      drive(1'b1, TwosMode, 32'h0907_9E70, 32'hF6F8_6190, 1'b0, 1'b0);
      drive(1'b1, TwosMode, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
      drive(1'b1, TwosMode, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
      drive(1'b1, TwosMode, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
      drive(1'b1, TwosMode, 32'h7FFF_FFFF, 32'h8000_0001, 1'b0, 1'b0);
      drive(1'b1, OnesMode, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      drive(1'b1, OnesMode, 32'h0907_9E70, 32'hF6F8_618F, 1'b0, 1'b0);
      drive(1'b1, OnesMode, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
      drive(1'b1, TwosMode, 32'h0000_FFFF, 32'hFFFF_0001, 1'b0, 1'b0);
      drive(1'b1, TwosMode, 32'h0000_0010, 32'hFFFF_FFF0, 1'b0, 1'b0);

      // Reset with a valid operand present: that operand must never appear.
      reset = 1'b0;
      drive(1'b1, TwosMode, 32'h1234_5678, 32'hEDCB_A988, 1'b0, 1'b0);
      check_idle("reset_drop", 32'h0000_0000, 1'b0, 1'b0);
      reset = 1'b1;

      drive(1'b1, TwosMode, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0, 1'b0);
      drive(1'b1, TwosMode, 32'h0000_0003, 32'hFFFF_FFFD, 1'b0, 1'b0);
      drive(1'b0, TwosMode, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
      check_idle("hold1", 32'hFFFF_FFFD, 1'b0, 1'b0);
      drive(1'b0, OnesMode, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
      check_idle("hold2", 32'hFFFF_FFFD, 1'b0, 1'b0);

      drive(1'b0, TwosMode, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/complementary_unit.md
# complementary_unit

Registered two's-complement negation unit for the nnARM datapath: it takes one `WordWidth`-bit operand per cycle and returns its arithmetic negation (or, optionally, bitwise inversion) one clock later with a valid strobe. It serves the ALU and the RSB/negate paths wherever a negated operand is needed. Optional status flags report zero results and overflow (negation of the most-negative value).

## Interface
- `WordWidth`, default 32: operand/result width; comes from the shared definitions include.
- `clock`  input  1  sole clock; rising-edge.
- `reset`  input  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- `in_Valid`  input  1  the operand is valid this cycle.
- `in_OnesComplement`  input  1  1 = bitwise invert only; 0 = two's complement (invert plus one).
- `in_Operand`  input  `WordWidth`  operand.
- `out_Valid`  output  1  the result is valid; high exactly one cycle after an accepted `in_Valid`.
- `out_Result`  output  `WordWidth`  result.
- `out_Zero`  output  1  the result is all zeros (flags build only).
- `out_Overflow`  output  1  two's-complement overflow (flags build only).

## Operation
- Two's mode: result = (~in_Operand + 1) mod 2^WordWidth.
- Ones mode: result = ~in_Operand.
- Every cycle with `in_Valid`=1 is accepted. There is no back-pressure and no stall.
- On a cycle with `in_Valid`=0:
  - `out_Valid` drops to 0 on the next edge.
  - `out_Result` and the flags hold their last values.
- Zero flag:
  - `out_Zero` = (result == 0).
  - Two's mode: true only for operand 0.
  - Ones mode: true only for operand all-ones.
- Overflow flag:
  - Two's mode: `out_Overflow` = 1 only for operand 0x8000_0000, where the result is also 0x8000_0000.
  - Ones mode: `out_Overflow` is always 0.
- The +1 is an incrementer, not a general adder. Its carry-out is discarded, so 0 negates to 0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear at the outputs after edge N.
- Throughput is 1 operand per cycle, back-to-back.
- Reset (`reset`=0 at an edge) forces `out_Valid`=0, `out_Result`=0, `out_Zero`=0, `out_Overflow`=0.
- Reset takes priority over `in_Valid` on the same edge. An operand presented during that edge is dropped.
- Reset asserted mid-stream drops any in-flight result. The first valid output after release comes from the first operand accepted after release.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `COMPLEMENTARY_FLAGS_EN` defined:
  - the `out_Zero` and `out_Overflow` ports and their registers exist;
  - both flags are computed as described under Operation.
- Not defined:
  - both ports are removed;
  - only `out_Valid` and `out_Result` remain;
  - result behaviour is identical.

## Structure
- The shared definitions package/include holds:
  - `WordWidth` (32);
  - `MostNegative` (32'h8000_0000);
  - the mode encoding constants (`TwosMode`=0, `OnesMode`=1).
- One natural sub-module, `complementary_core`:
  - purely combinational;
  - does the inversion plus a carry-lookahead incrementer in 4-bit groups;
  - produces the raw result, zero and overflow.
- The top level instantiates the core and owns the registers, valid pipeline and reset.

## Test plan
- Two's mode, operand 0x0907_9E70 with valid -> next cycle `out_Result`=0xF6F8_6190, `out_Valid`=1, Zero=0, Overflow=0.
- Two's mode, operands 0x0000_0000 then 0x0000_0001 back-to-back:
  - first result 0x0000_0000 with Zero=1;
  - second result 0xFFFF_FFFF;
  - `out_Valid` high for both cycles.
- Two's mode, operand 0x8000_0000 -> 0x8000_0000 with Overflow=1; operand 0x7FFF_FFFF -> 0x8000_0001 with Overflow=0.
- Ones mode, operand 0xFFFF_FFFF -> 0x0000_0000, Zero=1, Overflow=0; operand 0x0907_9E70 -> 0xF6F8_618F.
- Drive `reset`=0 for one edge while `in_Valid`=1 with operand 0x1234_5678:
  - all outputs 0 after that edge, and no valid result appears for that operand;
  - after release, operand 5 -> 0xFFFF_FFFB one cycle later.
- Drop `in_Valid` for 2 cycles after operand 3 -> `out_Valid` low for those cycles and `out_Result` holds 0xFFFF_FFFD.
